pipe_hazard_ctrl: RTL

//  Sequences the five-stage pipeline: drives en/clr of PC, IF/ID, ID/EX, EX/MEM and MEM/WB

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/div_hold_timer.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and helpers for the pipeline hazard controller.
//   state_e       : controller FSM states
//   hold_cause_e  : which hold rule won the priority mux this cycle (debug)
//   load_use_hit  : load-use comparator between EX destination and ID sources
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_DIV        = 2'd1,
    ST_FLUSH_PEND = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    HC_NONE       = 3'd0,
    HC_FLUSH      = 3'd1,
    HC_FLUSH_PEND = 3'd2,
    HC_MEM        = 3'd3,
    HC_DIV        = 3'd4,
    HC_LOAD_USE   = 3'd5,
    HC_IF         = 3'd6
  } hold_cause_e;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(
    input logic             mem_read,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt
  );
    return mem_read && (rd != '0) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/div_hold_timer.sv
// Purpose: countdown timer that holds EX while a multicycle divide runs.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load DIV_CYCLES-1 (divide start cycle)
//   i_dec        : decrement by one, saturating at zero
//   i_clear      : force count to zero (flush)
//   o_cnt_zero   : count is zero
module div_hold_timer #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  input  logic i_clear,
  output logic o_cnt_zero
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Clear beats load so a flush on a start cycle leaves nothing behind.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(DIV_CYCLES - 1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: five-stage pipeline sequencer. Drives enables and bubble clears of the
//   PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from exception, bus-wait,
//   divide and load-use events; owns the divide hold timer and defers exception
//   flushes while either AXI side is busy.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_id_rs, i_id_rt             : ID-stage source registers
//   i_ex_rd, i_ex_mem_read       : EX-stage destination, EX is a load
//   i_ex_div_start               : EX holds a DIV/DIVU (level)
//   i_if_stall, i_mem_stall      : I-side / D-side AXI access outstanding
//   i_exc_valid                  : exception on the MEM-stage instruction
//   o_en_*                       : pipeline register enables
//   o_clr_*                      : synchronous bubble inserts
//   o_pc_redirect                : PC loads the exception vector (pulse)
//   o_div_busy, o_div_done, o_div_abort : divide status
// Outputs are combinational from state, timer and inputs, forced to 0 in reset.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_div_start,
  input  logic             i_if_stall,
  input  logic             i_mem_stall,
  input  logic             i_exc_valid,
  output logic             o_en_pc,
  output logic             o_en_fd,
  output logic             o_en_de,
  output logic             o_en_em,
  output logic             o_en_mw,
  output logic             o_clr_fd,
  output logic             o_clr_de,
  output logic             o_clr_em,
  output logic             o_clr_mw,
  output logic             o_pc_redirect,
  output logic             o_div_busy,
  output logic             o_div_done,
  output logic             o_div_abort
);

  state_e      r_state;
  state_e      w_state_nxt;
  hold_cause_e w_cause;
  logic        w_cnt_zero;
  logic        w_load;
  logic        w_dec;
  logic        w_clear;
  logic        w_any_stall;
  logic        w_div_hold;
  logic        w_load_use;

  div_hold_timer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_hold_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_clear    (w_clear),
    .o_cnt_zero (w_cnt_zero)
  );

  assign w_any_stall = i_mem_stall || i_if_stall;
  assign w_load_use  = load_use_hit(i_ex_mem_read, i_ex_rd, i_id_rs, i_id_rt);
  // Start cycle holds EX before the timer is loaded; afterwards the timer decides.
  assign w_div_hold  = ((r_state == ST_RUN) && i_ex_div_start) ||
                       ((r_state == ST_DIV) && !w_cnt_zero);
  // Timer runs every DIV cycle, mem stall or not.
  assign w_dec       = (r_state == ST_DIV);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold priority: only the highest-ranked cause shapes the outputs.
  always_comb begin
    w_cause = HC_NONE;
    if ((r_state == ST_FLUSH_PEND) || i_exc_valid) begin
      // A pending flush fires even after exc_valid drops.
      w_cause = w_any_stall ? HC_FLUSH_PEND : HC_FLUSH;
    end else if (i_mem_stall) begin
      w_cause = HC_MEM;
    end else if (w_div_hold) begin
      w_cause = HC_DIV;
    end else if (w_load_use) begin
      w_cause = HC_LOAD_USE;
    end else if (i_if_stall) begin
      w_cause = HC_IF;
    end
  end

  // Next state, timer control and enable/clear outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_clear       = 1'b0;
    o_en_pc       = 1'b1;
    o_en_fd       = 1'b1;
    o_en_de       = 1'b1;
    o_en_em       = 1'b1;
    o_en_mw       = 1'b1;
    o_clr_fd      = 1'b0;
    o_clr_de      = 1'b0;
    o_clr_em      = 1'b0;
    o_clr_mw      = 1'b0;
    o_pc_redirect = 1'b0;
    o_div_busy    = (r_state == ST_DIV);
    o_div_done    = 1'b0;
    o_div_abort   = 1'b0;

    case (w_cause)
      HC_FLUSH: begin
        // Bubble every stage, including the excepting instruction in MEM.
        o_clr_fd      = 1'b1;
        o_clr_de      = 1'b1;
        o_clr_em      = 1'b1;
        o_clr_mw      = 1'b1;
        o_pc_redirect = 1'b1;
        o_div_abort   = (r_state == ST_DIV);
        w_clear       = 1'b1;
        w_state_nxt   = ST_RUN;
      end
      HC_FLUSH_PEND: begin
        o_en_pc     = 1'b0;
        o_en_fd     = 1'b0;
        o_en_de     = 1'b0;
        o_en_em     = 1'b0;
        o_en_mw     = 1'b0;
        w_state_nxt = ST_FLUSH_PEND;
      end
      HC_MEM: begin
        o_en_pc  = 1'b0;
        o_en_fd  = 1'b0;
        o_en_de  = 1'b0;
        o_en_em  = 1'b0;
        o_clr_mw = 1'b1;
      end
      HC_DIV: begin
        o_en_pc  = 1'b0;
        o_en_fd  = 1'b0;
        o_en_de  = 1'b0;
        o_clr_em = 1'b1;
      end
      HC_LOAD_USE: begin
        o_en_pc  = 1'b0;
        o_en_fd  = 1'b0;
        o_clr_de = 1'b1;
      end
      HC_IF: begin
        o_en_pc  = 1'b0;
        o_clr_fd = 1'b1;
      end
      default: begin
      end
    endcase

    // Divide sequencing for all non-flush causes.
    if ((w_cause != HC_FLUSH) && (w_cause != HC_FLUSH_PEND)) begin
      if ((r_state == ST_RUN) && i_ex_div_start) begin
        w_load      = 1'b1;
        w_state_nxt = ST_DIV;
      end else if (r_state == ST_DIV) begin
        // Completion waits out a mem stall so EX cannot slip past a frozen MEM.
        if (w_cnt_zero && !i_mem_stall) begin
          o_div_done  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end else begin
        w_state_nxt = ST_RUN;
      end
    end

    if (i_rst) begin
      w_load        = 1'b0;
      w_clear       = 1'b0;
      o_en_pc       = 1'b0;
      o_en_fd       = 1'b0;
      o_en_de       = 1'b0;
      o_en_em       = 1'b0;
      o_en_mw       = 1'b0;
      o_clr_fd      = 1'b0;
      o_clr_de      = 1'b0;
      o_clr_em      = 1'b0;
      o_clr_mw      = 1'b0;
      o_pc_redirect = 1'b0;
      o_div_busy    = 1'b0;
      o_div_done    = 1'b0;
      o_div_abort   = 1'b0;
      w_state_nxt   = ST_RUN;
    end
  end

endmodule
